// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - shared CPU run-state and run-controller state encodings
package cpu_run_ctrl_pkg;

    localparam logic CPU_IDLE = 1'b0;
    localparam logic CPU_EXEC = 1'b1;

    localparam logic [2:0] RC_IDLE      = 3'd0;
    localparam logic [2:0] RC_LAUNCH    = 3'd1;
    localparam logic [2:0] RC_WAIT_EXEC = 3'd2;
    localparam logic [2:0] RC_RUN       = 3'd3;
    localparam logic [2:0] RC_STOP      = 3'd4;
    localparam logic [2:0] RC_DONE      = 3'd5;

    // The CPU is only allowed to run while the controller owns a live launch.
    function automatic logic rc_cpu_enabled(input logic [2:0] st);
        return (st == RC_LAUNCH) || (st == RC_WAIT_EXEC) || (st == RC_RUN);
    endfunction

    function automatic logic rc_busy(input logic [2:0] st);
        return rc_cpu_enabled(st) || (st == RC_STOP);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - 32-bit up counter with clear, enable and a saturation limit
module sat_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] limit,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q < limit)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - launches the CPU, counts exec cycles, enforces budget and abort
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter logic [31:0] MAX_CYCLES = 32'd1_000_000,
    parameter int          ACK_WAIT   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        host_go,
    input  logic        host_abort,
    input  logic        cpu_state,
    output logic        enable,
    output logic        start,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        aborted,
    output logic        ack_err,
    output logic [31:0] cycle_count
);

    localparam int              AW          = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
    localparam logic [AW-1:0]   ACK_LAST    = AW'(ACK_WAIT - 1);
    localparam logic [31:0]     BUDGET_LAST = MAX_CYCLES - 32'd1;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] ack_cnt_q, ack_cnt_d;
    logic          enable_q, enable_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic          aborted_q, aborted_d;
    logic          ack_err_q, ack_err_d;
    logic          cnt_clr;
    logic          cnt_en;
    logic          cpu_exec;
    logic [31:0]   cycle_count_w;

    assign cpu_exec = (cpu_state == CPU_EXEC);

    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        aborted_d = aborted_q;
        ack_err_d = ack_err_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            RC_IDLE, RC_DONE: begin
                if (host_go) begin
                    state_d   = RC_LAUNCH;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    aborted_d = 1'b0;
                    ack_err_d = 1'b0;
                    cnt_clr   = 1'b1;
                end
            end
            RC_LAUNCH: begin
                state_d   = RC_WAIT_EXEC;
                ack_cnt_d = '0;
            end
            RC_WAIT_EXEC: begin
                cnt_en    = cpu_exec;
                ack_cnt_d = ack_cnt_q + AW'(1);
                if (host_abort) begin
                    aborted_d = 1'b1;
                    state_d   = RC_STOP;
                end else if (cpu_exec) begin
                    state_d = RC_RUN;
                end else if (ack_cnt_q == ACK_LAST) begin
                    ack_err_d = 1'b1;
                    state_d   = RC_STOP;
                end
            end
            RC_RUN: begin
                cnt_en = cpu_exec;
                // A retired HALT outranks abort, which outranks the budget.
                if (!cpu_exec) begin
                    done_d  = 1'b1;
                    state_d = RC_DONE;
                end else if (host_abort) begin
                    aborted_d = 1'b1;
                    state_d   = RC_STOP;
                end else if (cycle_count_w >= BUDGET_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = RC_STOP;
                end
            end
            RC_STOP: begin
                if (!cpu_exec) begin
                    done_d  = 1'b1;
                    state_d = RC_DONE;
                end
            end
            default: state_d = RC_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave flops directly.
        enable_d = rc_cpu_enabled(state_d);
        start_d  = (state_d == RC_LAUNCH);
        busy_d   = rc_busy(state_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= RC_IDLE;
            ack_cnt_q <= '0;
            enable_q  <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            aborted_q <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_cnt_q <= ack_cnt_d;
            enable_q  <= enable_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            aborted_q <= aborted_d;
            ack_err_q <= ack_err_d;
        end
    end

    sat_counter u_cycle_count (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (MAX_CYCLES),
        .count (cycle_count_w)
    );

    assign enable      = enable_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign aborted     = aborted_q;
    assign ack_err     = ack_err_q;
    assign cycle_count = cycle_count_w;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - randomized run scenarios against an outcome-level reference model
module tb_cpu_run_ctrl;

    localparam int MAXC = 50;
    localparam int ACKW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        host_go = 1'b0;
    logic        host_abort = 1'b0;
    logic        cpu_state = 1'b0;
    logic        enable, start, busy, done, timeout, aborted, ack_err;
    logic [31:0] cycle_count;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic cpu_next = 1'b0;
    int   cpu_len = 0;
    bit   cpu_noack = 1'b0;
    int   ex_cnt = 0;

    cpu_run_ctrl #(
        .MAX_CYCLES (32'd50),
        .ACK_WAIT   (ACKW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .host_go     (host_go),
        .host_abort  (host_abort),
        .cpu_state   (cpu_state),
        .enable      (enable),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .aborted     (aborted),
        .ack_err     (ack_err),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // CPU behaviour: enters exec after seeing start, halts after cpu_len exec cycles.
    task automatic cpu_model();
        if (!enable) begin
            cpu_next = 1'b0;
        end else if (start) begin
            cpu_next = !cpu_noack;
            ex_cnt   = 0;
        end else if (cpu_state) begin
            ex_cnt++;
            cpu_next = (ex_cnt < cpu_len);
        end else begin
            cpu_next = 1'b0;
        end
    endtask

    task automatic next_cycle(input logic go, input logic abort);
        @(posedge clock);
        #1;
        cyc++;
        cpu_state  = cpu_next;
        host_go    = go;
        host_abort = abort;
        @(negedge clock);
        cpu_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":enable"}, 32'(enable), 32'd0);
        check({tag, ":start"}, 32'(start), 32'd0);
        check({tag, ":busy"}, 32'(busy), 32'd0);
        check({tag, ":done"}, 32'(done), 32'd0);
        check({tag, ":timeout"}, 32'(timeout), 32'd0);
        check({tag, ":aborted"}, 32'(aborted), 32'd0);
        check({tag, ":ack_err"}, 32'(ack_err), 32'd0);
        check({tag, ":cycle_count"}, cycle_count, 32'd0);
    endtask

    // n: exec cycles before HALT; k: exec position of host_abort (0 = none).
    task automatic do_run(input int n, input int k, input bit noack, input string name);
        int   g, d, idle_c, done_c, en_fall, hp, ap, gap;
        int   exp_cnt;
        logic e_to, e_ab, e_ae, go_n, ab_n;

        cpu_len   = n;
        cpu_noack = noack;
        gap = $urandom_range(1, 3);
        repeat (gap) next_cycle(1'b0, 1'($urandom_range(0, 1)));
        next_cycle(1'b1, 1'b0);
        g = cyc;

        e_to = 1'b0;
        e_ab = 1'b0;
        e_ae = 1'b0;
        hp   = n + 1;
        ap   = (k == 0) ? 32'h3fff_ffff : k;
        if (noack) begin
            d       = g + 1 + ACKW;
            en_fall = d + 1;
            done_c  = d + 2;
            exp_cnt = 0;
            e_ae    = 1'b1;
        end else if (hp <= ap && hp <= MAXC) begin
            d       = g + 1 + hp;
            done_c  = d + 1;
            en_fall = done_c;
            exp_cnt = n;
        end else begin
            if (ap <= MAXC) begin
                d       = g + 1 + ap;
                exp_cnt = ap;
                e_ab    = 1'b1;
            end else begin
                d       = g + 1 + MAXC;
                exp_cnt = MAXC;
                e_to    = 1'b1;
            end
            en_fall = d + 1;
            idle_c  = (g + 1 + hp < d + 2) ? (g + 1 + hp) : (d + 2);
            done_c  = idle_c + 1;
        end

        for (int c = g + 1; c <= done_c; c++) begin
            go_n = (c < done_c) && ($urandom_range(0, 5) == 0);
            ab_n = !noack && (k != 0) && (c == g + 1 + k);
            next_cycle(go_n, ab_n);
            check({name, ":start"}, 32'(start), 32'(c == g + 1));
            check({name, ":busy"}, 32'(busy), 32'(c < done_c));
            check({name, ":enable"}, 32'(enable), 32'(c < en_fall));
            check({name, ":done"}, 32'(done), 32'(c == done_c));
            if (c <= d) begin
                check({name, ":flags_clear"}, 32'({timeout, aborted, ack_err}), 32'd0);
            end
            if (c == g + 1) begin
                check({name, ":count_cleared"}, cycle_count, 32'd0);
            end
        end
        check({name, ":cycle_count"}, cycle_count, 32'(exp_cnt));
        check({name, ":timeout"}, 32'(timeout), 32'(e_to));
        check({name, ":aborted"}, 32'(aborted), 32'(e_ab));
        check({name, ":ack_err"}, 32'(ack_err), 32'(e_ae));
    endtask

    initial begin
        bit r_na;
        int r_n;
        int r_k;

        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;

        do_run(10, 0, 1'b0, "normal");
        do_run(1000, 0, 1'b0, "timeout");
        do_run(1000, 7, 1'b0, "abort");
        do_run(0, 0, 1'b1, "noack");
        do_run(12, 13, 1'b0, "halt_vs_abort");
        do_run(20, 1, 1'b0, "abort_in_wait");
        do_run(49, 0, 1'b0, "halt_before_budget");
        do_run(50, 0, 1'b0, "halt_after_budget");
        do_run(1000, 50, 1'b0, "abort_vs_budget");
        do_run(7, 7, 1'b0, "abort_last_exec");

        for (int r = 0; r < 24; r++) begin
            r_na = ($urandom_range(0, 7) == 0);
            r_n  = $urandom_range(1, 70);
            r_k  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 60);
            do_run(r_n, r_k, r_na, "rand");
        end

        cpu_len   = 1000;
        cpu_noack = 1'b0;
        next_cycle(1'b1, 1'b0);
        repeat (8) next_cycle(1'b0, 1'b0);
        check("midrun:busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        cpu_model();
        next_cycle(1'b0, 1'b0);
        next_cycle(1'b0, 1'b0);
        reset = 1'b1;
        check_all_zero("after_reset");
        do_run(10, 0, 1'b0, "post_reset");
        do_run(1000, 0, 1'b0, "timeout_again");
        do_run(6, 0, 1'b0, "relaunch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
